// File: rtl/uart_tx_engine.sv
// UART transmit engine: shifts out start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
// Frame parameters are latched at acceptance; cts_n gates only the start of each frame.
module uart_tx_engine #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       start_tx,
  input  logic       cts_n,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_CTS, START, DATA, PARITY, STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       dbn_q, dbn_d;
  logic             sb_q, sb_d;
  logic             pen_q, pen_d;
  logic             pt_q, pt_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             term_c;
  logic [2:0]       last_idx_c;
  logic [7:0]       mask_c;
  logic             parity_c;

  assign term_c     = (cnt_q == CNT_LAST);
  assign last_idx_c = 3'd4 + {1'b0, dbn_q};
  assign mask_c     = 8'hFF >> (2'd3 - dbn_q);
  assign parity_c   = (^(data_q & mask_c)) ^ pt_q;

  // State register, shadow config and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      dbn_q   <= '0;
      sb_q    <= 1'b0;
      pen_q   <= 1'b0;
      pt_q    <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      dbn_q   <= dbn_d;
      sb_q    <= sb_d;
      pen_q   <= pen_d;
      pt_q    <= pt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: bit timing, bit index and shadow capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    dbn_d   = dbn_q;
    sb_d    = sb_q;
    pen_d   = pen_q;
    pt_d    = pt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (start_tx) begin
          data_d  = tx_data;
          dbn_d   = data_bit_num;
          sb_d    = stop_bit_num;
          pen_d   = parity_en;
          pt_d    = parity_type;
          state_d = cts_n ? WAIT_CTS : START;
        end
      end
      WAIT_CTS: begin
        cnt_d = '0;
        if (!cts_n) state_d = START;
      end
      START: begin
        if (term_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (term_c) begin
          cnt_d = '0;
          if (bit_q == last_idx_c) begin
            bit_d   = '0;
            state_d = pen_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (term_c) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (term_c) begin
          cnt_d = '0;
          if (sb_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            bit_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the next state so tx changes on the same edge as the FSM
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[bit_d];
      PARITY:  tx_d = parity_c;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine with CLKS_PER_BIT=16: table of frames plus
// flow-control, back-to-back and mid-frame reset sequences.
module tb_uart_tx_engine;

  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       start_tx;
  logic       cts_n;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_data      (tx_data),
    .start_tx     (start_tx),
    .cts_n        (cts_n),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  // One frame: config plus the hand-written line sequence, bit 0 = start bit
  typedef struct {
    logic [7:0]  data;
    logic [1:0]  dbn;
    logic        sb;
    logic        pen;
    logic        pt;
    int unsigned nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that produced the first start-bit cycle; ends in the tx_done cycle
  task automatic check_body(input vec_t v, input logic mid_pulse);
    int unsigned len;
    int unsigned early;
    logic        first;
    len   = v.nbits * CPB;
    early = 0;
    first = 1'b0;
    chk("busy_at_start", 32'(tx_busy), 32'd1);
    for (int c = 0; c < int'(len); c++) begin
      if (c > 0) tick();
      if (mid_pulse && c == 40) begin
        start_tx = 1'b1;
        tx_data  = 8'hFF;
      end
      if (mid_pulse && c == 41) start_tx = 1'b0;
      if (tx_done) early++;
      if ((c % CPB) == 0) first = tx;
      if ((c % CPB) == CPB - 1)
        chk($sformatf("bit%0d", c / CPB), 32'({first, tx}), 32'({2{v.bits[4'(c / CPB)]}}));
    end
    chk("no_early_done", early, 32'd0);
    tick();
    chk("done_at_end", 32'({tx_done, tx_busy, tx}), 32'b101);
  endtask

  task automatic load_cfg(input vec_t v);
    tx_data      = v.data;
    data_bit_num = v.dbn;
    stop_bit_num = v.sb;
    parity_en    = v.pen;
    parity_type  = v.pt;
  endtask

  task automatic send(input vec_t v);
    load_cfg(v);
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    tx_data  = ~v.data;
    chk("start_latency", 32'(tx), 32'd0);
    check_body(v, 1'b0);
  endtask

  initial begin
    vec_t v;
    int unsigned bad;

    // 8N1 0xA5, 7E2 0x41, 5O1 0xFF, 6N2 0x2C, 8O1 0x00
    vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 10, {2'b00, 1'b1, 8'hA5, 1'b0}};
    vecs[1] = '{8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 11, {1'b0, 2'b11, 1'b0, 7'h41, 1'b0}};
    vecs[2] = '{8'hFF, 2'b00, 1'b0, 1'b1, 1'b1,  8, {4'b0000, 1'b1, 1'b0, 5'h1F, 1'b0}};
    vecs[3] = '{8'h2C, 2'b01, 1'b1, 1'b0, 1'b0,  9, {3'b000, 2'b11, 6'h2C, 1'b0}};
    vecs[4] = '{8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 11, {1'b0, 1'b1, 1'b1, 8'h00, 1'b0}};

    reset = 1'b1;
    start_tx = 1'b0;
    cts_n = 1'b0;
    tx_data = 8'h00;
    data_bit_num = 2'b11;
    stop_bit_num = 1'b0;
    parity_en = 1'b0;
    parity_type = 1'b0;
    repeat (3) tick();
    chk("reset_state", 32'({tx, tx_busy, tx_done}), 32'b100);
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 32'({tx, tx_busy, tx_done}), 32'b100);

    for (int i = 0; i < 5; i++) begin
      send(vecs[i]);
      tick();
      chk("done_single_pulse", 32'({tx_done, tx}), 32'b01);
    end

    // Flow control: held 50 cycles, start on the cycle after cts_n falls, ignored mid-frame
    v = vecs[0];
    load_cfg(v);
    cts_n = 1'b1;
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) tick();
      if (!(tx === 1'b1 && tx_busy === 1'b1)) bad++;
    end
    chk("cts_hold", bad, 32'd0);
    cts_n = 1'b0;
    tick();
    chk("cts_release_start", 32'(tx), 32'd0);
    cts_n = 1'b1;
    check_body(v, 1'b0);
    cts_n = 1'b0;
    tick();

    // Back-to-back 0x12 then 0x34 requested in the tx_done cycle; mid-frame pulse ignored
    v = vecs[0];
    v.data = 8'h12;
    v.bits = {2'b00, 1'b1, 8'h12, 1'b0};
    send_with_pulse(v);
    v.data = 8'h34;
    v.bits = {2'b00, 1'b1, 8'h34, 1'b0};
    load_cfg(v);
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    chk("b2b_start", 32'(tx), 32'd0);
    check_body(v, 1'b0);
    tick();

    // Reset at cycle 70 of an 8N1 frame
    v = vecs[0];
    v.data = 8'hC3;
    load_cfg(v);
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    repeat (69) tick();
    reset = 1'b1;
    tick();
    chk("midframe_reset", 32'({tx, tx_busy, tx_done}), 32'b100);
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (tx_done !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("quiet_after_reset", bad, 32'd0);
    v.data = 8'h5A;
    v.bits = {2'b00, 1'b1, 8'h5A, 1'b0};
    send(v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  task automatic send_with_pulse(input vec_t v);
    load_cfg(v);
    start_tx = 1'b1;
    tick();
    start_tx = 1'b0;
    chk("start_latency", 32'(tx), 32'd0);
    check_body(v, 1'b1);
  endtask

endmodule
